// File: rtl/nib_track_sequencer_pkg.sv
// rtl/nib_track_sequencer_pkg.sv - shared states and geometry for the .NIB track sequencer
package apple2_disk_pkg;

    localparam int NIB_SECS  = 13;
    localparam int NIB_TRK_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_XFER,
        RD_REQ,
        RD_XFER
    } seq_state_t;

endpackage

// File: rtl/nib_track_sequencer_if.sv
// rtl/nib_track_sequencer_if.sv - SD block handshake between the sequencer and hps_io
interface nib_track_sequencer_if #(
    parameter int LBA_W = 32
);
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd;
    logic             sd_wr;
    logic             sd_ack;
    logic [3:0]       buf_sec;

    modport master (output sd_lba, output sd_rd, output sd_wr, output buf_sec, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, input buf_sec, output sd_ack);
endinterface

// File: rtl/nib_track_sequencer_sd_sector_hs.sv
// rtl/nib_track_sequencer_sd_sector_hs.sv - one-sector req/ack edge engine shared by RD and WR phases
module sd_sector_hs (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_wr,
    input  logic ack,
    output logic rd_req,
    output logic wr_req,
    output logic acked,
    output logic done
);

    logic ack_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack;
        end
    end

    assign acked  = ack & ~ack_q;
    assign done   = ~ack & ack_q;
    assign rd_req = start & ~is_wr;
    assign wr_req = start & is_wr;

endmodule

// File: rtl/nib_track_sequencer.sv
// rtl/nib_track_sequencer.sv - loads (and with TRACK_WRITEBACK_EN flushes) whole .NIB tracks via hps_io
module nib_track_sequencer
    import apple2_disk_pkg::*;
#(
    parameter int SECS  = NIB_SECS,
    parameter int TRK_W = NIB_TRK_W,
    parameter int LBA_W = 32
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [TRK_W-1:0]      track,
    input  logic                  img_mounted,
    input  logic                  img_present,
    input  logic                  trk_dirty,
    nib_track_sequencer_if.master sd,
    output logic                  cpu_wait,
    output logic                  busy,
    output logic [TRK_W-1:0]      loaded_trk
);

    seq_state_t       state, state_n;
    logic             valid, valid_n;
    logic             mount_pend, mount_n;
    logic [TRK_W-1:0] loaded_n;
    logic [3:0]       buf_sec, buf_n;
    logic             wait_n;
    logic             trigger, flush, last;
    logic             hs_rd, hs_wr, acked, done;

    sd_sector_hs u_hs (
        .clk    (clk_sys),
        .rst    (reset),
        .start  ((state == RD_REQ) || (state == WR_REQ)),
        .is_wr  (state == WR_REQ),
        .ack    (sd.sd_ack),
        .rd_req (hs_rd),
        .wr_req (hs_wr),
        .acked  (acked),
        .done   (done)
    );

    assign trigger = (state == IDLE) && (!valid || (track != loaded_trk) || mount_pend);
    assign last    = (buf_sec == 4'(SECS - 1));
    assign busy    = (state != IDLE);

    assign sd.sd_lba  = LBA_W'(loaded_trk) * LBA_W'(SECS) + LBA_W'(buf_sec);
    assign sd.sd_rd   = hs_rd;
    assign sd.buf_sec = buf_sec;

`ifdef TRACK_WRITEBACK_EN
    logic dirty, dirty_n, dirty_in;

    // a dirty byte landing in the same cycle as the trigger still forces a flush
    assign dirty_in  = dirty | (trk_dirty & valid);
    assign flush     = dirty_in & valid & ~mount_pend & ~img_mounted;
    assign sd.sd_wr  = hs_wr;

    always_comb begin
        dirty_n = dirty;
        if (img_mounted) begin
            dirty_n = 1'b0;
        end else if (state == IDLE) begin
            dirty_n = trigger ? (flush & img_present) : dirty_in;
        end else if ((state == WR_XFER) && done && last) begin
            dirty_n = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dirty <= 1'b0;
        end else begin
            dirty <= dirty_n;
        end
    end
`else
    logic unused_inputs;

    assign flush         = 1'b0;
    assign sd.sd_wr      = 1'b0;
    assign unused_inputs = trk_dirty | hs_wr;
`endif

    always_comb begin
        state_n  = state;
        valid_n  = valid;
        mount_n  = mount_pend | img_mounted;
        loaded_n = loaded_trk;
        buf_n    = buf_sec;
        wait_n   = cpu_wait;
        case (state)
            IDLE: begin
                if (trigger) begin
                    mount_n = img_mounted;
                    if (!img_present) begin
                        loaded_n = track;
                        valid_n  = 1'b1;
                    end else begin
                        buf_n  = 4'd0;
                        wait_n = 1'b1;
                        if (flush) begin
                            state_n = WR_REQ;
                        end else begin
                            loaded_n = track;
                            state_n  = RD_REQ;
                        end
                    end
                end
            end
`ifdef TRACK_WRITEBACK_EN
            WR_REQ: if (acked) state_n = WR_XFER;
            WR_XFER: begin
                if (done) begin
                    if (last) begin
                        buf_n    = 4'd0;
                        loaded_n = track;
                        state_n  = RD_REQ;
                    end else begin
                        buf_n   = buf_sec + 4'd1;
                        state_n = WR_REQ;
                    end
                end
            end
`endif
            RD_REQ: if (acked) state_n = RD_XFER;
            RD_XFER: begin
                if (done) begin
                    if (last) begin
                        buf_n   = 4'd0;
                        valid_n = 1'b1;
                        wait_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        buf_n   = buf_sec + 4'd1;
                        state_n = RD_REQ;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= 1'b0;
            mount_pend <= 1'b0;
            loaded_trk <= '0;
            buf_sec    <= 4'd0;
            cpu_wait   <= 1'b0;
        end else begin
            state      <= state_n;
            valid      <= valid_n;
            mount_pend <= mount_n;
            loaded_trk <= loaded_n;
            buf_sec    <= buf_n;
            cpu_wait   <= wait_n;
        end
    end

endmodule
